jk_drive_seq: RTL

Command sequencer that sits directly upstream of the team's jk_ff and drives its j/k inputs.
- Accepts HOLD/RESET/SET/TOGGLE commands with a repeat length over a valid/ready handshake.
- Buffers the commands in a small FIFO.
- Replays each command on j/k for the requested number of clock cycles.
- Shares clk/rst with the jk_ff it drives. q_in is fed back from jk_ff.q for optional checking.

---
 rtl/jk_drive_seq_if.sv | 13 +
 rtl/jk_drive_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/jk_drive_seq_if.sv
// Command handshake bundle between a command source and jk_drive_seq.
// Carries valid/ready plus the {j,k} op and the repeat length.
interface jk_drive_seq_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_drive_seq.sv
// Queues JK drive commands and replays each on j/k for len+1 cycles.
// Optional JK_CHECK_EN builds a shadow flip-flop that flags q_in disagreement.
//
// state   | meaning
// S_IDLE  | nothing driving, j=k=0, waiting for a queued command
// S_APPLY | driving the current op, rem_q counts remaining extra cycles
module jk_drive_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  jk_drive_seq_if.slave   cmd,
  output logic            j_o,
  output logic            k_o,
  output logic            busy_o,
  output logic            done_o,
  input  logic            q_in_i,
  output logic            mismatch_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = CNT_W + 2;

  typedef enum logic {S_IDLE, S_APPLY} state_t;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len;

  state_t           state_q, state_d;
  logic [1:0]       jk_q, jk_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign cmd.cmd_ready = !full && !rst;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign {head_op, head_len} = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd.cmd_op, cmd.cmd_len};
    end
  end

  always_comb begin
    state_d = state_q;
    jk_d    = jk_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        jk_d = 2'b00;
        if (!empty) begin
          pop     = 1'b1;
          jk_d    = head_op;
          rem_d   = head_len;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end else if (!empty) begin
          pop   = 1'b1;
          jk_d  = head_op;
          rem_d = head_len;
        end else begin
          jk_d    = 2'b00;
          rem_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      jk_q     <= 2'b00;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      jk_q     <= jk_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign j_o    = jk_q[1];
  assign k_o    = jk_q[0];
  assign busy_o = (state_q == S_APPLY);
  assign done_o = busy_o && (rem_q == '0);

`ifdef JK_CHECK_EN
  logic exp_q, mismatch_q;

  // exp_q tracks what the downstream jk_ff should hold given our own drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      case (jk_q)
        2'b10:   exp_q <= 1'b1;
        2'b01:   exp_q <= 1'b0;
        2'b11:   exp_q <= ~exp_q;
        default: exp_q <= exp_q;
      endcase
      if (q_in_i != exp_q) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign mismatch_o = mismatch_q;
`else
  logic unused_q_in;
  assign unused_q_in = q_in_i;
  assign mismatch_o  = 1'b0;
`endif

endmodule
